// File: rtl/rv32_pkg.sv
// Shared RV32 decode definitions: opcodes, immediate formats, ID/EX control bundle.
package rv32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic jump_r;
        logic alu_src;
        logic is_mul;
        logic illegal;
    } ctrl_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_e t);
        logic [31:0] imm;
        case (t)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Register-file write port driven by the WB stage into ID.
interface id_stage_if;
    import rv32_pkg::*;

    // wb_we qualifies wb_rd/wb_data; there is no back-pressure, so an asserted write always lands.
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (output wb_we, wb_rd, wb_data);
    modport slave  (input  wb_we, wb_rd, wb_data);
endinterface

// File: rtl/regfile.sv
// 32x32 register file: two async read ports with WB bypass, one sync write port, x0 hardwired to 0.
module regfile
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'b0;
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // A same-cycle WB write to the register being read is forwarded.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (raddr1 == 5'd0)                 rdata1 = 32'b0;
        else if (we && (waddr == raddr1))   rdata1 = wdata;
        if (raddr2 == 5'd0)                 rdata2 = 32'b0;
        else if (we && (waddr == raddr2))   rdata2 = wdata;
    end

endmodule

// File: rtl/id_stage.sv
// RV32 decode stage: IF/ID register, decoder, load-use stall, ID/EX register.
// Define RV32M_DECODE_EN to accept the M-extension R-type encodings (id_is_mul).
module id_stage
    import rv32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_in,
    input  logic [31:0]       pc_in,
    input  logic              flush,
    id_stage_if.slave         wb,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    output logic              stall,
    output logic              id_valid,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_rs1val,
    output logic [31:0]       id_rs2val,
    output logic [31:0]       id_imm,
    output logic [4:0]        id_rs1,
    output logic [4:0]        id_rs2,
    output logic [4:0]        id_rd,
    output logic [2:0]        id_funct3,
    output logic [6:0]        id_funct7,
    output logic              id_reg_write,
    output logic              id_mem_read,
    output logic              id_mem_write,
    output logic              id_branch,
    output logic              id_jump,
    output logic              id_jump_r,
    output logic              id_alu_src,
    output logic              id_is_mul,
    output logic              id_illegal
);

    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2;
    logic [6:0]  funct7;
    ctrl_t       dec;
    imm_type_e   imm_t;
    logic        use_rs1, use_rs2;
    logic [31:0] rs1val, rs2val;
    ctrl_t       id_ctrl;

    assign opcode = ifid_instr[6:0];
    assign rs1    = ifid_instr[19:15];
    assign rs2    = ifid_instr[24:20];
    assign funct7 = ifid_instr[31:25];

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_instr <= 32'b0;
            ifid_pc    <= 32'b0;
            ifid_valid <= 1'b0;
        end else if (flush) begin
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            ifid_instr <= instr_in;
            ifid_pc    <= pc_in;
            ifid_valid <= 1'b1;
        end
    end

    always_comb begin
        dec     = '0;
        imm_t   = IMM_R;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
`ifdef RV32M_DECODE_EN
                dec.reg_write = 1'b1;
                dec.is_mul    = (funct7 == FUNCT7_MULDIV);
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
`else
                if (funct7 == FUNCT7_MULDIV) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.reg_write = 1'b1;
                    use_rs1       = 1'b1;
                    use_rs2       = 1'b1;
                end
`endif
            end
            OP_I:      begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; imm_t = IMM_I; use_rs1 = 1'b1; end
            OP_LOAD:   begin dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.alu_src = 1'b1;
                             imm_t = IMM_I; use_rs1 = 1'b1; end
            OP_STORE:  begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; imm_t = IMM_S;
                             use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_BRANCH: begin dec.branch = 1'b1; imm_t = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_JAL:    begin dec.jump = 1'b1; dec.reg_write = 1'b1; imm_t = IMM_J; end
            OP_JALR:   begin dec.jump_r = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
                             imm_t = IMM_I; use_rs1 = 1'b1; end
            OP_LUI,
            OP_AUIPC:  begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; imm_t = IMM_U; end
            default:   dec.illegal = 1'b1;
        endcase
    end

    // Only rs fields the instruction really reads can create a load-use hazard.
    assign stall = ifid_valid && ex_mem_read && (ex_rd != 5'd0) && !flush &&
                   ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));

    regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1val),
        .rdata2 (rs2val),
        .we     (wb.wb_we),
        .waddr  (wb.wb_rd),
        .wdata  (wb.wb_data)
    );

    always_ff @(posedge clk) begin
        id_valid  <= 1'b0;
        id_pc     <= 32'b0;
        id_rs1val <= 32'b0;
        id_rs2val <= 32'b0;
        id_imm    <= 32'b0;
        id_rs1    <= 5'b0;
        id_rs2    <= 5'b0;
        id_rd     <= 5'b0;
        id_funct3 <= 3'b0;
        id_funct7 <= 7'b0;
        id_ctrl   <= '0;
        if (!(rst || flush || stall) && ifid_valid) begin
            if (dec.illegal) begin
                id_ctrl.illegal <= 1'b1;
            end else begin
                id_valid  <= 1'b1;
                id_pc     <= ifid_pc;
                id_rs1val <= rs1val;
                id_rs2val <= rs2val;
                id_imm    <= gen_imm(ifid_instr, imm_t);
                id_rs1    <= rs1;
                id_rs2    <= rs2;
                id_rd     <= ifid_instr[11:7];
                id_funct3 <= ifid_instr[14:12];
                id_funct7 <= funct7;
                id_ctrl   <= dec;
            end
        end
    end

    assign id_reg_write = id_ctrl.reg_write;
    assign id_mem_read  = id_ctrl.mem_read;
    assign id_mem_write = id_ctrl.mem_write;
    assign id_branch    = id_ctrl.branch;
    assign id_jump      = id_ctrl.jump;
    assign id_jump_r    = id_ctrl.jump_r;
    assign id_alu_src   = id_ctrl.alu_src;
    assign id_is_mul    = id_ctrl.is_mul;
    assign id_illegal   = id_ctrl.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode formats, bypass, load-use stall, flush, illegal, M config.
module tb_id_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in, pc_in;
  logic        flush, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1val, id_rs2val, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump;
  logic        id_jump_r, id_alu_src, id_is_mul, id_illegal;

  int checks = 0;
  int failures = 0;

  id_stage_if wb_bus ();

  id_stage dut (
    .clk          (clk),
    .rst          (rst),
    .instr_in     (instr_in),
    .pc_in        (pc_in),
    .flush        (flush),
    .wb           (wb_bus),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .stall        (stall),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_rs1val    (id_rs1val),
    .id_rs2val    (id_rs2val),
    .id_imm       (id_imm),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_funct3    (id_funct3),
    .id_funct7    (id_funct7),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_mem_write (id_mem_write),
    .id_branch    (id_branch),
    .id_jump      (id_jump),
    .id_jump_r    (id_jump_r),
    .id_alu_src   (id_alu_src),
    .id_is_mul    (id_is_mul),
    .id_illegal   (id_illegal)
  );

  always #5 clk = ~clk;

  // {reg_write, mem_read, mem_write, branch, jump, jump_r, alu_src, is_mul, illegal}
  logic [8:0]   ctl;
  logic [162:0] id_all;
  assign ctl = {id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump,
                id_jump_r, id_alu_src, id_is_mul, id_illegal};
  assign id_all = {id_valid, id_pc, id_rs1val, id_rs2val, id_imm, id_rs1, id_rs2,
                   id_rd, id_funct3, id_funct7, ctl};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    instr_in = instr;
    pc_in    = pc;
    step();
    instr_in = NOP;
    step();
  endtask

  initial begin
    rst = 1'b1; instr_in = NOP; pc_in = 32'h0; flush = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    wb_bus.wb_we = 1'b0; wb_bus.wb_rd = 5'd0; wb_bus.wb_data = 32'h0;
    step();
    rst = 1'b0;

    // addi x1,x5,0 with x5 written by WB in the decode cycle
    instr_in = 32'h00028093; pc_in = 32'h4;
    step();
    instr_in = NOP;
    wb_bus.wb_we = 1'b1; wb_bus.wb_rd = 5'd5; wb_bus.wb_data = 32'h1234;
    step();
    wb_bus.wb_we = 1'b0;
    chk("bypass_x5_valid", id_valid, 1'b1);
    chk("bypass_x5_rs1val", id_rs1val, 32'h1234);

    // reset while a load-use stall is pending
    instr_in = 32'h00028093;
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    #1;
    chk("stall_rs1_hazard", stall, 1'b1);
    rst = 1'b1;
    step();
    chk("reset_id_all_zero", id_all, '0);
    chk("reset_stall_zero", stall, 1'b0);
    rst = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0; instr_in = NOP;
    step();
    chk("post_reset_bubble_valid", id_valid, 1'b0);
    chk("post_reset_bubble_illegal", id_illegal, 1'b0);
    issue(32'h00028093, 32'h8);
    chk("reset_x5_reads_zero", id_rs1val, 32'h0);
    chk("reset_x5_issue_valid", id_valid, 1'b1);

    // addi x1,x0,5
    issue(32'h00500093, 32'h10);
    chk("addi_valid", id_valid, 1'b1);
    chk("addi_pc", id_pc, 32'h10);
    chk("addi_imm", id_imm, 32'h5);
    chk("addi_rd", id_rd, 5'd1);
    chk("addi_ctl", ctl, 9'b100000100);

    // sw x2,-4(x1)
    issue(32'hFE20AE23, 32'h14);
    chk("sw_imm", id_imm, 32'hFFFFFFFC);
    chk("sw_ctl", ctl, 9'b001000100);
    chk("sw_funct3", id_funct3, 3'b010);
    // beq x1,x2,-8
    issue(32'hFE208CE3, 32'h18);
    chk("beq_imm", id_imm, 32'hFFFFFFF8);
    chk("beq_ctl", ctl, 9'b000100000);
    // lui x5,0x12345
    issue(32'h123452B7, 32'h1C);
    chk("lui_imm", id_imm, 32'h12345000);
    chk("lui_rd", id_rd, 5'd5);
    chk("lui_ctl", ctl, 9'b100000100);
    // jal x1,+16
    issue(32'h010000EF, 32'h20);
    chk("jal_imm", id_imm, 32'h10);
    chk("jal_ctl", ctl, 9'b100010000);

    // WB bypass of x3, then stored value, then x0 write ignored
    instr_in = 32'h00018213; pc_in = 32'h50;
    step();
    instr_in = NOP;
    wb_bus.wb_we = 1'b1; wb_bus.wb_rd = 5'd3; wb_bus.wb_data = 32'hDEADBEEF;
    step();
    wb_bus.wb_we = 1'b0;
    chk("bypass_x3", id_rs1val, 32'hDEADBEEF);
    issue(32'h00018213, 32'h54);
    chk("stored_x3", id_rs1val, 32'hDEADBEEF);
    instr_in = 32'h00000213;
    step();
    instr_in = NOP;
    wb_bus.wb_we = 1'b1; wb_bus.wb_rd = 5'd0; wb_bus.wb_data = 32'hFFFFFFFF;
    step();
    wb_bus.wb_we = 1'b0;
    chk("x0_bypass_zero", id_rs1val, 32'h0);
    issue(32'h00000213, 32'h58);
    chk("x0_stored_zero", id_rs1val, 32'h0);

    // load-use on add x9,x7,x2
    wb_bus.wb_we = 1'b1; wb_bus.wb_rd = 5'd7; wb_bus.wb_data = 32'h11;
    step();
    wb_bus.wb_rd = 5'd2; wb_bus.wb_data = 32'h22;
    step();
    wb_bus.wb_we = 1'b0;
    instr_in = 32'h002384B3; pc_in = 32'h40;
    step();
    instr_in = 32'h00500093; pc_in = 32'h44;
    ex_mem_read = 1'b1; ex_rd = 5'd7;
    #1;
    chk("loaduse_stall", stall, 1'b1);
    step();
    chk("loaduse_bubble_valid", id_valid, 1'b0);
    chk("loaduse_bubble_ctl", ctl, 9'b0);
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    #1;
    chk("loaduse_stall_release", stall, 1'b0);
    step();
    chk("add_valid", id_valid, 1'b1);
    chk("add_pc", id_pc, 32'h40);
    chk("add_fields", {id_rs1, id_rs2, id_rd, id_funct7}, {5'd7, 5'd2, 5'd9, 7'd0});
    chk("add_rs1val", id_rs1val, 32'h11);
    chk("add_rs2val", id_rs2val, 32'h22);
    chk("add_ctl", ctl, 9'b100000000);
    instr_in = NOP;
    step();
    chk("held_instr_pc", id_pc, 32'h44);
    chk("held_instr_imm", id_imm, 32'h5);

    // rs2 field of an I-type is not a source; ex_rd=0 never stalls
    instr_in = 32'h00500093;
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    #1;
    chk("itype_rs2_no_stall", stall, 1'b0);
    ex_rd = 5'd0;
    #1;
    chk("exrd_zero_no_stall", stall, 1'b0);

    // flush beats a stall driven by rs2
    instr_in = 32'h002384B3;
    step();
    instr_in = NOP;
    ex_rd = 5'd2;
    #1;
    chk("stall_rs2_hazard", stall, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_kills_stall", stall, 1'b0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_bubble_valid", id_valid, 1'b0);
    chk("flush_bubble_illegal", id_illegal, 1'b0);
    chk("flush_ifid_invalid_no_stall", stall, 1'b0);
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    step();
    chk("invalid_entry_bubble", {id_valid, id_illegal}, 2'b00);

    // illegal opcode, pulse lasts one cycle
    issue(32'hFFFFFFFF, 32'h60);
    chk("illegal_flag", id_illegal, 1'b1);
    chk("illegal_valid", id_valid, 1'b0);
    chk("illegal_ctl", ctl, 9'b000000001);
    step();
    chk("illegal_one_cycle", id_illegal, 1'b0);
    chk("after_illegal_valid", id_valid, 1'b1);

    // mul x0,x1,x2
    issue(32'h02208033, 32'h64);
`ifdef RV32M_DECODE_EN
    chk("mul_ctl", ctl, 9'b100000010);
    chk("mul_valid", id_valid, 1'b1);
`else
    chk("mul_ctl", ctl, 9'b000000001);
    chk("mul_valid", id_valid, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have ports: clk in 1 (sole clock, rising edge); rst in 1 (synchronous, active-high reset).
REQ-002 SHALL have ports: instr_in in 32 (fetched instruction); pc_in in 32 (PC of instr_in, same-cycle aligned); flush in 1 (EX redirect: branch taken, JAL or JALR).
REQ-003 SHALL have ports: wb_we in 1; wb_rd in 5; wb_data in 32 (register-file write port from WB).
REQ-004 SHALL have ports: ex_mem_read in 1; ex_rd in 5 (load currently in EX, for hazard detection).
REQ-005 SHALL have outputs: stall out 1 (combinational; freezes IF PC and holds IF/ID).
REQ-006 SHALL have registered ID/EX outputs: id_valid 1, id_pc 32, id_rs1val 32, id_rs2val 32, id_imm 32, id_rs1 5, id_rs2 5, id_rd 5, id_funct3 3, id_funct7 7.
REQ-007 SHALL have registered control outputs: id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_jump_r, id_alu_src, id_is_mul, id_illegal, each 1 bit.

Function
REQ-008 SHALL hold an IF/ID register (instr, pc, valid), loaded each edge unless stall; valid set to 1 on load.
REQ-009 SHALL decode IF/ID contents combinationally and capture results into ID/EX on the next edge: instr_in to id_* latency exactly 2 edges.
REQ-010 SHALL decode opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC; any other opcode is illegal.
REQ-011 SHALL generate sign-extended immediates: I, S, B (bit0=0), U (low 12 bits 0), J (bit0=0); R-type imm = 0.
REQ-012 SHALL contain a 32x32 register file; x0 reads 0; writes with wb_rd=0 ignored.
REQ-013 SHALL bypass WB to read: wb_we=1, wb_rd=rsN!=0 -> id_rsNval = wb_data in same cycle.
REQ-014 SHALL assert stall when IF/ID valid, ex_mem_read=1, ex_rd!=0, and ex_rd equals an rs field actually used by the instruction (rs2 only for R, store, branch).
REQ-015 On stall SHALL hold IF/ID and load a bubble into ID/EX (id_valid=0, all control outputs 0).
REQ-016 On flush SHALL clear IF/ID valid and load a bubble into ID/EX; flush has priority over stall; stall deasserts that cycle.
REQ-017 Illegal instruction SHALL produce id_valid=0, all other controls 0, id_illegal=1 for exactly one cycle.
REQ-018 Invalid IF/ID entry SHALL produce a bubble with id_illegal=0 and SHALL NOT assert stall.

Reset
REQ-019 On rst=1 at a clock edge SHALL clear IF/ID valid and every ID/EX output to 0; rst overrides flush and stall.
REQ-020 Register file contents SHALL reset to 0 (all 32 entries) on the same edge.
REQ-021 Reset asserted mid-stall SHALL leave stall=0 in the following cycle.

Configuration
REQ-022 With RV32M_DECODE_EN defined, opcode 0110011 with funct7=0000001 SHALL decode as valid R-type with id_is_mul=1.
REQ-023 Without RV32M_DECODE_EN, that encoding SHALL be illegal per REQ-017 and id_is_mul SHALL be tied 0.

Structure
REQ-024 SHALL take opcode constants, immediate-type enum and ID/EX control struct from shared package rv32_pkg.
REQ-025 SHALL instantiate register file as sub-module regfile (2 async read ports, 1 sync write port, bypass inside).

Verification
REQ-026 Reset: rst=1 one edge -> all id_* = 0, stall=0; read of x5 returns 0.
REQ-027 Decode: instr_in=0x00500093 (addi x1,x0,5), pc_in=0x10 -> after 2 edges id_valid=1, id_imm=5, id_rd=1, id_reg_write=1, id_alu_src=1, id_pc=0x10.
REQ-028 Load-use: ex_mem_read=1, ex_rd=7, IF/ID holds 0x002384b3 (add x9,x7,x2) -> stall=1 one cycle, ID/EX bubble, then add issues with id_valid=1.
REQ-029 Bypass: wb_we=1, wb_rd=3, wb_data=0xDEADBEEF while decoding rs1=3 -> id_rs1val=0xDEADBEEF next edge; wb_rd=0 write -> x0 still reads 0.
REQ-030 Flush priority: flush=1 with stall condition present -> stall=0, id_valid=0 next edge, IF/ID invalid.
REQ-031 Config: instr 0x02208033 (mul x0,x1,x2) -> id_is_mul=1 with RV32M_DECODE_EN; id_illegal=1 one cycle without.
